// File: rtl/dm_bridge.sv
// dm_bridge: CPU data-memory port to req/ack bus bridge.
// Ports: CPU side (mem_w, mem_r, addr, wdata, dm_ctrl, rdata, stall,
//   misalign, err), bus side (bus_req, bus_we, bus_addr, bus_be,
//   bus_wdata, bus_ack, bus_rdata). Optional DM_TIMEOUT_EN adds
//   a REQ wait limit of TIMEOUT cycles that aborts with err.
module dm_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  off;
  logic [2:0]  ctrl;
  logic        req_in;
  logic        is_half;
  logic        is_byte;
  logic        mis_addr;
  logic        idle;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx;
  logic [31:0] sh;
  logic [15:0] lane_h;
  logic [7:0]  lane_b;
  logic [31:0] ld_ext;

  assign req_in  = mem_w | mem_r;
  assign is_half = (dm_ctrl == 3'b001) | (dm_ctrl == 3'b010);
  assign is_byte = (dm_ctrl == 3'b011) | (dm_ctrl == 3'b100);
  assign mis_addr = (is_half & addr[0])
                  | (~is_half & ~is_byte & (|addr[1:0]));
  assign idle     = (state == S_IDLE);
  assign misalign = idle & req_in & mis_addr;
  assign stall    = (idle & req_in & ~mis_addr)
                  | (state == S_REQ);
  assign bus_req  = (state == S_REQ);

  always_comb begin
    be_nx = 4'b1111;
    wd_nx = wdata;
    unique case (1'b1)
      is_byte: begin
        be_nx = 4'b0001 << addr[1:0];
        wd_nx = {4{wdata[7:0]}};
      end
      is_half: begin
        be_nx = addr[1] ? 4'b1100 : 4'b0011;
        wd_nx = {2{wdata[15:0]}};
      end
      default: begin
        be_nx = 4'b1111;
        wd_nx = wdata;
      end
    endcase
  end

  // Lane select uses the offset captured at request time.
  assign sh     = bus_rdata >> {off, 3'b000};
  assign lane_h = sh[15:0];
  assign lane_b = sh[7:0];

  always_comb begin
    ld_ext = bus_rdata;
    case (ctrl)
      3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
      3'b010:  ld_ext = {16'h0, lane_h};
      3'b011:  ld_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  ld_ext = {24'h0, lane_b};
      default: ld_ext = bus_rdata;
    endcase
  end

`ifdef DM_TIMEOUT_EN
  logic [15:0] cnt;
  logic        to;
  assign err = (state == S_DONE) & to;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rdata     <= 32'h0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      off       <= 2'b00;
      ctrl      <= 3'b000;
`ifdef DM_TIMEOUT_EN
      cnt       <= 16'h0;
      to        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef DM_TIMEOUT_EN
          cnt <= 16'h0;
          to  <= 1'b0;
`endif
          if (req_in && !mis_addr) begin
            state     <= S_REQ;
            bus_we    <= mem_w;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_nx;
            bus_wdata <= wd_nx;
            off       <= addr[1:0];
            ctrl      <= dm_ctrl;
          end
        end
        S_REQ: begin
`ifdef DM_TIMEOUT_EN
          // Ack on the limit cycle still completes normally.
          if (bus_ack) begin
            if (!bus_we) rdata <= ld_ext;
            state <= S_DONE;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            rdata <= 32'h0;
            to    <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 16'h1;
          end
`else
          if (bus_ack) begin
            if (!bus_we) rdata <= ld_ext;
            state <= S_DONE;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dm_bridge.md
# dm_bridge

Data-memory bridge between the CPU's memory port and a handshaked (req/ack) data bus. It takes the CPU's memory request: `mem_w`/`mem_r`, `Addr_out`, `Data_out` and `dm_ctrl`. It generates word-aligned bus transactions with byte enables and lane-replicated store data, and returns sign- or zero-extended load data as the CPU's `Data_in`. It stalls the CPU while a transaction is outstanding. It also detects misaligned accesses and drops them without touching the bus.

## Interface
- `TIMEOUT`, 255: maximum bus wait cycles in REQ before abort. Used only with `DM_TIMEOUT_EN`. Range 1..65535.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_w`  in  1  CPU store request.
- `mem_r`  in  1  CPU load request.
- `addr`  in  32  CPU byte address (ALU output).
- `wdata`  in  32  CPU store data (rs2).
- `dm_ctrl`  in  3  access type: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned. Codes 101–111 are treated as word.
- `rdata`  out  32  extended load data to the CPU write-back mux.
- `stall`  out  1  CPU must hold PC and pipeline state.
- `misalign`  out  1  one-cycle pulse: the access was dropped.
- `err`  out  1  one-cycle pulse: bus timeout.
- `bus_req`  out  1  transaction valid.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables; bit n covers byte lane n (`[8n+7:8n]`).
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  slave completion, valid only while `bus_req`=1.
- `bus_rdata`  in  32  read word, valid with `bus_ack`.

## Operation
- **FSM:** IDLE → REQ → DONE → IDLE.
- **IDLE:**
  - Sample a request when `mem_w | mem_r`.
  - If both are set, the store wins.
  - Misaligned requests are half with `addr[0]`=1, or word with `addr[1:0]`≠0. For these, pulse `misalign` combinationally this cycle, keep `stall`=0 and stay in IDLE.
  - Aligned requests: register addr, we, be, wdata, lane offset and dm_ctrl, then go to REQ.
- **REQ:**
  - `bus_req`=1, with all bus outputs held stable from the registered copy.
  - On `bus_ack`: for a load, capture the extended `bus_rdata` into `rdata`; then go to DONE.
- **DONE:**
  - `stall`=0 and `rdata` is valid; the CPU advances on this edge.
  - Request inputs are ignored; the next state is IDLE.
- **`stall`** = (IDLE & aligned request) | REQ. It is combinational.
- **Store encoding:**
  - byte: be=`4'b0001<<addr[1:0]`, wdata=`{4{wdata[7:0]}}`.
  - half: be=`addr[1]?1100:0011`, wdata=`{2{wdata[15:0]}}`.
  - word: be=`1111`, wdata unchanged.
- **Load encoding:**
  - `bus_be` is set per size as for stores; `bus_we`=0.
  - Select the lane by the offset.
  - Codes 000/001/011 sign-extend; 010/100 zero-extend.
- **`rdata`** holds its last value outside DONE. It is unchanged after a store.

## Timing
- **Reset values:** state IDLE; `rdata`=0; `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0; `misalign`=0; `err`=0.
- **`stall`** is 0 in reset, since it derives from IDLE with no request.
- **Latency:** an aligned access with `bus_ack` in the first REQ cycle takes 3 cycles (IDLE, REQ, DONE), with `stall` high for 2 cycles. Each extra wait cycle adds 1.
- **Misaligned access:** 1 cycle, no bus activity, no stall.
- **Back-to-back accesses:** the next request is sampled in the IDLE cycle after DONE.
- **`bus_req`** never deasserts in REQ before `bus_ack`. The exceptions are reset and timeout.
- **`rst_n` low mid-transaction:** the state returns to IDLE and `bus_req` drops immediately, asynchronously. The slave must tolerate the abandoned request.
- **`bus_ack` outside REQ** is ignored.

## Configuration
- **Macro `DM_TIMEOUT_EN`:**
  - When defined, a wait counter clears on entry to REQ and increments each REQ cycle without `bus_ack`.
  - When it reaches `TIMEOUT`, `bus_req` drops and the FSM goes to DONE.
  - In that DONE, `err`=1 and `rdata`=0.
  - An ack arriving in the same cycle as the limit takes priority and completes normally.
- **Without the macro:** no counter is built, REQ waits indefinitely, and `err` is tied to 0.

## Test plan
- Store byte: addr=0x1003, wdata=0x000000A5, dm_ctrl=011, ack after 1 cycle → `bus_be`=1000, `bus_wdata`=0xA5A5A5A5, `bus_addr`=0x1000, `stall` high for 2 cycles.
- Load signed half: addr=0x2002, dm_ctrl=001, `bus_rdata`=0x8001_7FFF → `rdata`=0xFFFF8001. Repeat with dm_ctrl=010 → `rdata`=0x00008001.
- Load signed byte: addr=0x2001, `bus_rdata`=0x0000_8000, dm_ctrl=011 → `rdata`=0xFFFFFF80. Ack delayed 5 cycles → `stall` high for 6 cycles, `bus_addr` stable throughout.
- Misaligned: word load at 0x3002 → `misalign` pulses for 1 cycle, `bus_req` stays 0, `stall` stays 0. Also check that `mem_w` and `mem_r` both high at 0x3000 issues a write.
- Reset mid-op: drop `rst_n` during REQ → `bus_req`=0 in the same cycle. After release, the first request completes normally.
- With `DM_TIMEOUT_EN` and TIMEOUT=4, no ack → `bus_req` drops after 4 REQ cycles, `err` pulses with `rdata`=0, then IDLE.
